// File: rtl/stack_pkg.sv
// Shared constants for the parametrised operand stack.
package stack_pkg;

    localparam int DEF_DBITS = 32;
    localparam int DEF_DEPTH = 16;

    localparam int ERR_W   = 3;
    localparam int ERR_OP  = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_OVF = 2;

endpackage

// File: rtl/stack_reg_file_p_if.sv
// Operation and status bundle between the datapath and the operand stack.
interface stack_reg_file_p_if
    import stack_pkg::*;
#(
    parameter int DBITS = DEF_DBITS,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             en1;
    logic             en2;
    logic             we;
    logic             clr;
    logic             err_clr;
    logic [DBITS-1:0] din;
    logic [DBITS-1:0] dout1;
    logic [DBITS-1:0] dout2;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             err_ovf;
    logic             err_unf;
    logic             err_op;

    modport master (
        output en1, en2, we, clr, err_clr, din,
        input  dout1, dout2, count, empty, full,
        input  err_ovf, err_unf, err_op
    );

    modport slave (
        input  en1, en2, we, clr, err_clr, din,
        output dout1, dout2, count, empty, full,
        output err_ovf, err_unf, err_op
    );

endinterface

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, two asynchronous read ports.
module stack_mem #(
    parameter int DBITS = 32,
    parameter int DEPTH = 16,
    parameter int CW    = 5,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [DBITS-1:0] wd,
    input  logic [CW-1:0]    ra1,
    input  logic [CW-1:0]    ra2,
    output logic [DBITS-1:0] rd1,
    output logic [DBITS-1:0] rd2
);

    logic [DBITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    // Read addresses may wrap when the stack is shallow; the top masks those.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 < CW'(DEPTH)) rd1 = mem[ra1[AW-1:0]];
        if (ra2 < CW'(DEPTH)) rd2 = mem[ra2[AW-1:0]];
    end

endmodule

// File: rtl/stack_reg_file_p.sv
// LIFO operand stack: atomic pop-0/1/2 plus push, checked with sticky errors.
module stack_reg_file_p
    import stack_pkg::*;
#(
    parameter int DBITS = DEF_DBITS,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic             clk,
    input logic             rst_n,
    stack_reg_file_p_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    pops;
    logic [CW-1:0]    base;
    logic [CW-1:0]    ra1;
    logic [CW-1:0]    ra2;
    logic [DBITS-1:0] rd1;
    logic [DBITS-1:0] rd2;
    logic [ERR_W-1:0] err;
    logic [ERR_W-1:0] err_new;
    logic [ERR_W-1:0] err_next;
    logic             is_op;
    logic             is_unf;
    logic             is_ovf;
    logic             legal;
    logic             wr;

    assign pops = CW'(bus.en1) + CW'(bus.en2);

    // Checks are chained so base is only meaningful once underflow is ruled out.
    always_comb begin
        is_op  = bus.en2 & ~bus.en1;
        is_unf = ~is_op & (pops > count);
        base   = count - pops;
        is_ovf = ~is_op & ~is_unf & bus.we & (base == CW'(DEPTH));
        legal  = ~bus.clr & ~is_op & ~is_unf & ~is_ovf;
        wr     = legal & bus.we;
    end

    always_comb begin
        count_next = count;
        if (bus.clr)    count_next = '0;
        else if (legal) count_next = base + CW'(bus.we);
    end

    always_comb begin
        err_new = '0;
        if (!bus.clr) begin
            err_new[ERR_OP]  = is_op;
            err_new[ERR_UNF] = is_unf;
            err_new[ERR_OVF] = is_ovf;
        end
        err_next = (bus.err_clr ? '0 : err) | err_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            err   <= '0;
        end else begin
            count <= count_next;
            err   <= err_next;
        end
    end

    assign ra1 = count - CW'(1);
    assign ra2 = count - CW'(2);

    stack_mem #(
        .DBITS (DBITS),
        .DEPTH (DEPTH),
        .CW    (CW),
        .AW    (AW)
    ) u_mem (
        .clk (clk),
        .we  (wr),
        .wa  (base[AW-1:0]),
        .wd  (bus.din),
        .ra1 (ra1),
        .ra2 (ra2),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    assign bus.dout1   = (count >= CW'(1)) ? rd1 : '0;
    assign bus.dout2   = (count >= CW'(2)) ? rd2 : '0;
    assign bus.count   = count;
    assign bus.empty   = (count == '0);
    assign bus.full    = (count == CW'(DEPTH));
    assign bus.err_op  = err[ERR_OP];
    assign bus.err_unf = err[ERR_UNF];
    assign bus.err_ovf = err[ERR_OVF];

endmodule

// File: tb/tb_stack_reg_file_p.sv
// Drives a 16-deep and a 4-deep stack in lockstep against a queue-style model.
module tb_stack_reg_file_p;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    stack_reg_file_p_if #(.DBITS(32), .DEPTH(16)) b16 ();
    stack_reg_file_p_if #(.DBITS(32), .DEPTH(4))  b4 ();

    stack_reg_file_p #(.DBITS(32), .DEPTH(16)) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16.slave)
    );

    stack_reg_file_p #(.DBITS(32), .DEPTH(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays indexed by occupancy.
    int          mdep [2] = '{16, 4};
    int          mcnt [2];
    logic [31:0] mmem [2][16];
    bit          mop  [2];
    bit          munf [2];
    bit          movf [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mop[k]  = 0;
            munf[k] = 0;
            movf[k] = 0;
        end
    endfunction

    function automatic void model_step(int k, bit e1, bit e2,
                                       bit w, bit c, bit ec,
                                       logic [31:0] d);
        int  p;
        bit  nop, nunf, novf;
        p    = int'(e1) + int'(e2);
        nop  = 0;
        nunf = 0;
        novf = 0;
        if (c) begin
            mcnt[k] = 0;
        end else if (e2 && !e1) begin
            nop = 1;
        end else if (p > mcnt[k]) begin
            nunf = 1;
        end else if (w && (mcnt[k] - p == mdep[k])) begin
            novf = 1;
        end else begin
            mcnt[k] = mcnt[k] - p;
            if (w) begin
                mmem[k][mcnt[k]] = d;
                mcnt[k]++;
            end
        end
        if (ec) begin
            mop[k]  = 0;
            munf[k] = 0;
            movf[k] = 0;
        end
        mop[k]  = mop[k]  | nop;
        munf[k] = munf[k] | nunf;
        movf[k] = movf[k] | novf;
    endfunction

    function automatic logic [31:0] m_top(int k, int off);
        if (mcnt[k] >= off) return mmem[k][mcnt[k] - off];
        return 32'h0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("u16.count", 32'(b16.count), 32'(mcnt[0]));
        chk("u16.dout1", b16.dout1, m_top(0, 1));
        chk("u16.dout2", b16.dout2, m_top(0, 2));
        chk("u16.empty", 32'(b16.empty), 32'(mcnt[0] == 0));
        chk("u16.full",  32'(b16.full),  32'(mcnt[0] == 16));
        chk("u16.errs",
            {29'd0, b16.err_ovf, b16.err_unf, b16.err_op},
            {29'd0, movf[0], munf[0], mop[0]});
        chk("u4.count", 32'(b4.count), 32'(mcnt[1]));
        chk("u4.dout1", b4.dout1, m_top(1, 1));
        chk("u4.dout2", b4.dout2, m_top(1, 2));
        chk("u4.empty", 32'(b4.empty), 32'(mcnt[1] == 0));
        chk("u4.full",  32'(b4.full),  32'(mcnt[1] == 4));
        chk("u4.errs",
            {29'd0, b4.err_ovf, b4.err_unf, b4.err_op},
            {29'd0, movf[1], munf[1], mop[1]});
    endtask

    task automatic drive(bit e1, bit e2, bit w, bit c, bit ec,
                         logic [31:0] d);
        b16.en1 = e1; b16.en2 = e2; b16.we = w;
        b16.clr = c;  b16.err_clr = ec; b16.din = d;
        b4.en1  = e1; b4.en2  = e2; b4.we  = w;
        b4.clr  = c;  b4.err_clr  = ec; b4.din  = d;
    endtask

    task automatic cycle(bit e1, bit e2, bit w, bit c, bit ec,
                         logic [31:0] d);
        @(negedge clk);
        drive(e1, e2, w, c, ec, d);
        for (int k = 0; k < 2; k++) model_step(k, e1, e2, w, c, ec, d);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic push(logic [31:0] d);
        cycle(0, 0, 1, 0, 0, d);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) push(32'(i));
        chk("seq.count4", 32'(b16.count), 32'd4);
        chk("seq.top3",   b16.dout1, 32'd3);
        chk("seq.sec2",   b16.dout2, 32'd2);
        chk("seq.u4full", 32'(b4.full), 32'd1);

        cycle(1, 1, 1, 0, 0, 32'd4);
        chk("pop2push.count", 32'(b16.count), 32'd3);
        chk("pop2push.top",   b16.dout1, 32'd4);
        chk("pop2push.sec",   b16.dout2, 32'd1);

        cycle(1, 0, 0, 0, 0, 32'h0);
        chk("pop1.top", b16.dout1, 32'd1);
        chk("pop1.sec", b16.dout2, 32'd0);
        cycle(1, 1, 0, 0, 0, 32'h0);
        chk("pop2.empty", 32'(b16.empty), 32'd1);
        cycle(1, 0, 0, 0, 0, 32'h0);
        chk("unf.flag",  32'(b16.err_unf), 32'd1);
        chk("unf.count", 32'(b16.count), 32'd0);
        cycle(0, 0, 0, 0, 1, 32'h0);

        for (int i = 0; i < 3; i++) push(32'h100 + 32'(i));
        mid_reset();
        chk("rst.count", 32'(b16.count), 32'd0);
        chk("rst.top",   b16.dout1, 32'd0);

        for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
        chk("ovf.full", 32'(b4.full), 32'd1);
        push(32'h14);
        chk("ovf.flag", 32'(b4.err_ovf), 32'd1);
        chk("ovf.top",  b4.dout1, 32'h13);
        cycle(1, 0, 1, 0, 0, 32'hA);
        chk("fullrep.count", 32'(b4.count), 32'd4);
        chk("fullrep.top",   b4.dout1, 32'hA);

        cycle(0, 0, 0, 0, 1, 32'h0);
        cycle(0, 1, 0, 0, 0, 32'h0);
        chk("op.flag", 32'(b16.err_op), 32'd1);
        chk("op.unf",  32'(b16.err_unf), 32'd0);
        cycle(0, 1, 0, 0, 1, 32'h0);
        chk("op.setwins", 32'(b16.err_op), 32'd1);
        cycle(0, 0, 0, 0, 1, 32'h0);
        chk("op.cleared", 32'(b16.err_op), 32'd0);

        cycle(0, 0, 0, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++) push(32'h20 + 32'(i));
        cycle(0, 0, 1, 1, 0, 32'd9);
        chk("clr.count", 32'(b16.count), 32'd0);
        chk("clr.flags", 32'(b16.err_ovf), 32'd0);
        push(32'd7);
        chk("clr.push", b16.dout1, 32'd7);

        for (int i = 0; i < 600; i++) begin
            bit e1, e2, w, c, ec;
            e1 = ($urandom % 2) == 0;
            e2 = (($urandom % 8) == 0) ? 1'b1
                 : (e1 && ($urandom % 3) == 0);
            w  = ($urandom % 10) < 6;
            c  = ($urandom % 40) == 0;
            ec = ($urandom % 12) == 0;
            cycle(e1, e2, w, c, ec, $urandom);
            if (($urandom % 150) == 0) mid_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
